// File: rtl/obi_axil_bridge_pkg.sv
// Shared types and constants for the core data-port to AXI4-Lite bridge.
package tinyriscv_bus_pkg;

  // Bridge FSM states (one outstanding transaction, reads and writes share it)
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_WRESP = 3'd2,
    ST_RD_AR = 3'd3,
    ST_RD_R  = 3'd4
  } bridge_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Unprivileged, secure, data access
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  // SLVERR and DECERR both report as an error to the core (resp[1] set)
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/obi_axil_bridge_if.sv
// Bus bundles for the bridge: the core-side req/gnt/rvalid port and the
// AXI4-Lite master port. Signal names carry the bridge's port suffixes.

interface obi_bus_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    data_req_i;
  logic                    data_gnt_o;
  logic                    data_rvalid_o;
  logic                    data_we_i;
  logic [DATA_WIDTH/8-1:0] data_be_i;
  logic [ADDR_WIDTH-1:0]   data_addr_i;
  logic [DATA_WIDTH-1:0]   data_wdata_i;
  logic [DATA_WIDTH-1:0]   data_rdata_o;
  logic                    data_err_o;

  // Core side
  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );

  // Bridge side
  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );
endinterface

interface axil_bus_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    m_awvalid_o;
  logic                    m_awready_i;
  logic [ADDR_WIDTH-1:0]   m_awaddr_o;
  logic [2:0]              m_awprot_o;
  logic                    m_wvalid_o;
  logic                    m_wready_i;
  logic [DATA_WIDTH-1:0]   m_wdata_o;
  logic [DATA_WIDTH/8-1:0] m_wstrb_o;
  logic                    m_bvalid_i;
  logic                    m_bready_o;
  logic [1:0]              m_bresp_i;
  logic                    m_arvalid_o;
  logic                    m_arready_i;
  logic [ADDR_WIDTH-1:0]   m_araddr_o;
  logic [2:0]              m_arprot_o;
  logic                    m_rvalid_i;
  logic                    m_rready_o;
  logic [DATA_WIDTH-1:0]   m_rdata_i;
  logic [1:0]              m_rresp_i;

  // Bridge side (AXI master)
  modport master (
    output m_awvalid_o, m_awaddr_o, m_awprot_o,
    output m_wvalid_o, m_wdata_o, m_wstrb_o,
    output m_bready_o,
    output m_arvalid_o, m_araddr_o, m_arprot_o,
    output m_rready_o,
    input  m_awready_i, m_wready_i, m_bvalid_i, m_bresp_i,
    input  m_arready_i, m_rvalid_i, m_rdata_i, m_rresp_i
  );

  // Interconnect side (AXI slave)
  modport slave (
    input  m_awvalid_o, m_awaddr_o, m_awprot_o,
    input  m_wvalid_o, m_wdata_o, m_wstrb_o,
    input  m_bready_o,
    input  m_arvalid_o, m_araddr_o, m_arprot_o,
    input  m_rready_o,
    output m_awready_i, m_wready_i, m_bvalid_i, m_bresp_i,
    output m_arready_i, m_rvalid_i, m_rdata_i, m_rresp_i
  );
endinterface

// File: rtl/obi_axil_bridge.sv
// Core data-port (req/gnt/rvalid) to AXI4-Lite master bridge.
// One transaction in flight; the request is latched at grant and replayed
// unchanged on AXI. The response comes back as a one-cycle rvalid pulse.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   IDLE     | no transaction; grant any request
//   WR       | AW and/or W still waiting for their handshakes
//   WRESP    | both write channels done, waiting for B
//   RD_AR    | AR valid, waiting for arready
//   RD_R     | waiting for R
module obi_axil_bridge
  import tinyriscv_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  obi_bus_if.slave   obi,
  axil_bus_if.master axi
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  bridge_state_e         state_q, state_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [STRB_WIDTH-1:0] be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;

  logic gnt;
  logic awvalid, wvalid;
  logic aw_hs, w_hs;

  // Gated by rst_n so that every output reads 0 while reset is held
  assign gnt = rst_n && obi.data_req_i && (state_q == ST_IDLE);

  assign awvalid = (state_q == ST_WR) && !aw_done_q;
  assign wvalid  = (state_q == ST_WR) && !w_done_q;
  assign aw_hs   = awvalid && axi.m_awready_i;
  assign w_hs    = wvalid && axi.m_wready_i;

  assign obi.data_gnt_o    = gnt;
  assign obi.data_rvalid_o = rvalid_q;
  assign obi.data_rdata_o  = rdata_q;
  assign obi.data_err_o    = err_q;

  assign axi.m_awvalid_o = awvalid;
  assign axi.m_awaddr_o  = addr_q;
  assign axi.m_awprot_o  = PROT_DEFAULT;
  assign axi.m_wvalid_o  = wvalid;
  assign axi.m_wdata_o   = wdata_q;
  assign axi.m_wstrb_o   = be_q;
  assign axi.m_bready_o  = (state_q == ST_WRESP);
  assign axi.m_arvalid_o = (state_q == ST_RD_AR);
  assign axi.m_araddr_o  = addr_q;
  assign axi.m_arprot_o  = PROT_DEFAULT;
  assign axi.m_rready_o  = (state_q == ST_RD_R);

  // Next-state, request capture and response generation
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt) begin
          addr_d  = obi.data_addr_i;
          be_d    = obi.data_be_i;
          wdata_d = obi.data_wdata_i;
          state_d = obi.data_we_i ? ST_WR : ST_RD_AR;
        end
      end
      ST_WR: begin
        // AW and W complete independently, in any order or together
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          state_d   = ST_WRESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      ST_WRESP: begin
        if (axi.m_bvalid_i) begin
          rvalid_d = 1'b1;
          err_d    = resp_is_err(axi.m_bresp_i);
          rdata_d  = '0;
          state_d  = ST_IDLE;
        end
      end
      ST_RD_AR: begin
        if (axi.m_arready_i) begin
          state_d = ST_RD_R;
        end
      end
      ST_RD_R: begin
        if (axi.m_rvalid_i) begin
          rvalid_d = 1'b1;
          err_d    = resp_is_err(axi.m_rresp_i);
          rdata_d  = axi.m_rdata_i;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_obi_axil_bridge.sv
// Scoreboard bench for obi_axil_bridge: directed requests push their expected
// response; a monitor pops and compares on every data_rvalid_o and checks
// AXI valid/payload stability. A configurable AXI slave model drives the bus.
module tb_obi_axil_bridge;
  import tinyriscv_bus_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  logic clk;
  logic rst_n;

  obi_bus_if  #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) obi ();
  axil_bus_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  obi_axil_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .obi   (obi),
    .axi   (axi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_resp = 0;
  int   resp_cyc = 0;
  int   aw_hi = 0, w_hi = 0, ar_hi = 0;

  // slave model knobs
  int            cfg_aw_lat = 0, cfg_w_lat = 0, cfg_ar_lat = 0;
  logic [1:0]    cfg_bresp = RESP_OKAY, cfg_rresp = RESP_OKAY;
  logic [DW-1:0] cfg_rdata = '0;
  bit            cfg_b_block = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: timed out, got no event, expected one (t=%0t)", name, $time);
  endtask

  // ---------------- AXI slave model ----------------
  bit   got_aw, got_w, got_ar;
  int   aw_cnt, w_cnt, ar_cnt;
  logic s_awv, s_wv, s_arv, s_bready, s_rready;

  task automatic slave_clear();
    got_aw = 0; got_w = 0; got_ar = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    s_awv = 0; s_wv = 0; s_arv = 0; s_bready = 0; s_rready = 0;
    axi.m_awready_i = 0; axi.m_wready_i = 0; axi.m_arready_i = 0;
    axi.m_bvalid_i = 0; axi.m_bresp_i = 2'b00;
    axi.m_rvalid_i = 0; axi.m_rresp_i = 2'b00; axi.m_rdata_i = '0;
  endtask

  initial begin
    slave_clear();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        slave_clear();
      end else begin
        // handshakes that completed at the preceding rising edge
        if (s_awv && axi.m_awready_i) begin got_aw = 1; aw_cnt = 0; end
        else if (s_awv) aw_cnt++;
        if (s_wv && axi.m_wready_i) begin got_w = 1; w_cnt = 0; end
        else if (s_wv) w_cnt++;
        if (s_arv && axi.m_arready_i) begin got_ar = 1; ar_cnt = 0; end
        else if (s_arv) ar_cnt++;
        if (axi.m_bvalid_i && s_bready) axi.m_bvalid_i = 0;
        if (axi.m_rvalid_i && s_rready) axi.m_rvalid_i = 0;
        if (got_aw && got_w && !axi.m_bvalid_i && !cfg_b_block) begin
          axi.m_bvalid_i = 1; axi.m_bresp_i = cfg_bresp;
          got_aw = 0; got_w = 0;
        end
        if (got_ar && !axi.m_rvalid_i) begin
          axi.m_rvalid_i = 1; axi.m_rresp_i = cfg_rresp; axi.m_rdata_i = cfg_rdata;
          got_ar = 0;
        end
        s_awv = axi.m_awvalid_o; s_wv = axi.m_wvalid_o; s_arv = axi.m_arvalid_o;
        s_bready = axi.m_bready_o; s_rready = axi.m_rready_o;
        axi.m_awready_i = axi.m_awvalid_o && (aw_cnt >= cfg_aw_lat);
        axi.m_wready_i  = axi.m_wvalid_o && (w_cnt >= cfg_w_lat);
        axi.m_arready_i = axi.m_arvalid_o && (ar_cnt >= cfg_ar_lat);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic          p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [DW-1:0] p_wdata;
  logic [3:0]    p_wstrb;

  initial begin
    exp_t e;
    p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
    p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_wstrb = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        p_awv = 0; p_wv = 0; p_arv = 0;
      end else begin
        if (obi.data_rvalid_o) begin
          n_resp++;
          resp_cyc = cyc;
          if (exp_q.size() == 0) begin
            timeout("resp_unexpected_no_entry");
          end else begin
            e = exp_q.pop_front();
            check("resp_rdata", obi.data_rdata_o, e.rdata);
            check("resp_err", obi.data_err_o, e.err);
          end
        end else begin
          check("err_without_rvalid", obi.data_err_o, 0);
        end
        if (p_awv && !p_awr) check("aw_held", {axi.m_awvalid_o, axi.m_awaddr_o}, {1'b1, p_awaddr});
        if (p_wv && !p_wr)   check("w_held", {axi.m_wvalid_o, axi.m_wstrb_o, axi.m_wdata_o}, {1'b1, p_wstrb, p_wdata});
        if (p_arv && !p_arr) check("ar_held", {axi.m_arvalid_o, axi.m_araddr_o}, {1'b1, p_araddr});
        check("wr_rd_overlap", (axi.m_awvalid_o || axi.m_wvalid_o) && axi.m_arvalid_o, 0);
        check("bready_early", axi.m_bready_o && (axi.m_awvalid_o || axi.m_wvalid_o), 0);
        if (axi.m_awvalid_o) aw_hi++;
        if (axi.m_wvalid_o)  w_hi++;
        if (axi.m_arvalid_o) ar_hi++;
        p_awv = axi.m_awvalid_o; p_awr = axi.m_awready_i; p_awaddr = axi.m_awaddr_o;
        p_wv  = axi.m_wvalid_o;  p_wr  = axi.m_wready_i;  p_wdata = axi.m_wdata_o; p_wstrb = axi.m_wstrb_o;
        p_arv = axi.m_arvalid_o; p_arr = axi.m_arready_i; p_araddr = axi.m_araddr_o;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic scramble_inputs();
    obi.data_we_i    = ~obi.data_we_i;
    obi.data_addr_i  = 32'hFFFF_FFFC;
    obi.data_be_i    = 4'b1010;
    obi.data_wdata_i = 32'h5555_AAAA;
  endtask

  task automatic drive_req(input logic we, input logic [AW-1:0] addr,
                           input logic [3:0] be, input logic [DW-1:0] wdata);
    obi.data_req_i   = 1'b1;
    obi.data_we_i    = we;
    obi.data_addr_i  = addr;
    obi.data_be_i    = be;
    obi.data_wdata_i = wdata;
  endtask

  // called right after inputs are driven at a falling edge
  task automatic wait_gnt(input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (obi.data_gnt_o) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) timeout(name);
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [3:0] be,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] erd, input logic eerr,
                       output int rq_cyc, output int g_cyc);
    bit   ok;
    exp_t e;
    @(negedge clk);
    drive_req(we, addr, be, wdata);
    rq_cyc = cyc;
    wait_gnt("grant", ok);
    g_cyc = cyc;
    if (ok) begin
      e.rdata = erd;
      e.err   = eerr;
      exp_q.push_back(e);
    end
    @(negedge clk);
    obi.data_req_i = 1'b0;
    scramble_inputs();
  endtask

  task automatic wait_resp(input int target);
    int i;
    i = 0;
    while (n_resp < target && i < 60) begin
      @(negedge clk);
      #2;
      i++;
    end
    if (n_resp < target) timeout("response");
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {obi.data_gnt_o, obi.data_rvalid_o, obi.data_err_o,
                           axi.m_awvalid_o, axi.m_wvalid_o, axi.m_bready_o,
                           axi.m_arvalid_o, axi.m_rready_o}, 0);
    check({name, "_rdata"}, obi.data_rdata_o, 0);
    check({name, "_addr"}, {axi.m_awaddr_o, axi.m_araddr_o}, 0);
    check({name, "_wdata"}, {axi.m_wstrb_o, axi.m_wdata_o}, 0);
    check({name, "_prot"}, {axi.m_awprot_o, axi.m_arprot_o}, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int   rq, g, g1, g2, nexp;
    bit   ok;
    exp_t e;
    nexp = 0;
    rst_n = 1'b0;
    obi.data_req_i = 1'b1;  // held during reset: grant must stay low
    obi.data_we_i = 1'b0; obi.data_be_i = '0; obi.data_addr_i = '0; obi.data_wdata_i = '0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset_state");
    obi.data_req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: read, always-ready slave
    cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = RESP_OKAY;
    issue(1'b0, 32'h2000_0010, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, rq, g);
    #1;
    check("rd_arvalid_cycle1", {axi.m_arvalid_o, axi.m_araddr_o, axi.m_arprot_o}, {1'b1, 32'h2000_0010, 3'b000});
    nexp++; wait_resp(nexp);
    check("rd_latency", resp_cyc - g, 3);

    // 3: W before AW, SLVERR
    cfg_aw_lat = 2; cfg_w_lat = 0; cfg_bresp = RESP_SLVERR;
    issue(1'b1, 32'h2000_0008, 4'hF, 32'hCAFE_0001, 32'h0, 1'b1, rq, g);
    nexp++; wait_resp(nexp);
    check("wr_slverr_latency", resp_cyc - g, 5);

    // 2: write, awready delayed 3 cycles, wready immediate
    cfg_aw_lat = 3; cfg_w_lat = 0; cfg_bresp = RESP_OKAY;
    aw_hi = 0; w_hi = 0;
    issue(1'b1, 32'h2000_0004, 4'b0011, 32'h1234_5678, 32'h0, 1'b0, rq, g);
    #1;
    check("wr_payload", {axi.m_awaddr_o, axi.m_wstrb_o, axi.m_wdata_o, axi.m_awprot_o},
          {32'h2000_0004, 4'b0011, 32'h1234_5678, 3'b000});
    nexp++; wait_resp(nexp);
    check("wr_awvalid_cycles", aw_hi, 4);
    check("wr_wvalid_cycles", w_hi, 1);
    check("wr_latency", resp_cyc - g, 6);

    // 4: back-to-back read then write, req held high
    cfg_aw_lat = 0; cfg_rdata = 32'hCAFE_F00D; cfg_rresp = RESP_OKAY; cfg_bresp = RESP_OKAY;
    @(negedge clk);
    drive_req(1'b0, 32'h3000_0000, 4'hF, 32'h0);
    wait_gnt("b2b_gnt1", ok);
    g1 = cyc;
    if (ok) begin e.rdata = 32'hCAFE_F00D; e.err = 1'b0; exp_q.push_back(e); nexp++; end
    @(negedge clk);
    drive_req(1'b1, 32'h3000_0008, 4'hF, 32'hA5A5_A5A5);
    wait_gnt("b2b_gnt2", ok);
    g2 = cyc;
    if (ok) begin
      check("b2b_rvalid_at_gnt2", obi.data_rvalid_o, 1);
      check("b2b_gnt_spacing", g2 - g1, 3);
      e.rdata = 32'h0; e.err = 1'b0; exp_q.push_back(e); nexp++;
    end
    @(negedge clk);
    obi.data_req_i = 1'b0;
    scramble_inputs();
    wait_resp(nexp);
    check("b2b_wr_latency", resp_cyc - g2, 3);

    // 5: read with arready low 10 cycles, DECERR
    cfg_ar_lat = 10; cfg_rdata = 32'h0BAD_0BAD; cfg_rresp = RESP_DECERR;
    ar_hi = 0;
    issue(1'b0, 32'h4000_0020, 4'hF, 32'h0, 32'h0BAD_0BAD, 1'b1, rq, g);
    nexp++; wait_resp(nexp);
    check("rd_arvalid_cycles", ar_hi, 11);
    check("rd_decerr_latency", resp_cyc - g, 13);

    // 6: reset while in WRESP
    cfg_ar_lat = 0; cfg_rresp = RESP_OKAY; cfg_b_block = 1'b1;
    issue(1'b1, 32'h5000_0000, 4'hF, 32'h7777_7777, 32'h0, 1'b0, rq, g);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (axi.m_bready_o) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) timeout("wresp_reached");
    #1;
    obi.data_req_i = 1'b1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    cfg_b_block = 1'b0;
    obi.data_req_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cfg_rdata = 32'h1122_3344;
    issue(1'b0, 32'h6000_0004, 4'hF, 32'h0, 32'h1122_3344, 1'b0, rq, g);
    check("post_reset_gnt_immediate", g - rq, 0);
    nexp++; wait_resp(nexp);
    check("post_reset_latency", resp_cyc - g, 3);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("response_count", n_resp, nexp);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/obi_axil_bridge.md
Name: obi_axil_bridge

Overview:
- Converts the core's data-side req/gnt/rvalid port into an AXI4-Lite master.
- Sits directly downstream of the core's data access interface and upstream of the SoC interconnect.
- Single outstanding transaction; read and write share one FSM.
- Bus errors (SLVERR/DECERR) are returned to the core on the error output.

Parameters:
- ADDR_WIDTH, 32, address width on both sides
- DATA_WIDTH, 32, data width on both sides; strobe width is DATA_WIDTH/8

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- data_req_i  input  1  core request
- data_gnt_o  output  1  request accepted (address phase done)
- data_rvalid_o  output  1  response valid, single-cycle pulse
- data_we_i  input  1  1=write, 0=read
- data_be_i  input  DATA_WIDTH/8  byte enables
- data_addr_i  input  ADDR_WIDTH  byte address
- data_wdata_i  input  DATA_WIDTH  write data
- data_rdata_o  output  DATA_WIDTH  read data, valid with data_rvalid_o
- data_err_o  output  1  bus error, valid with data_rvalid_o
- m_awvalid_o / m_awready_i / m_awaddr_o[ADDR_WIDTH] / m_awprot_o[3]  AXI write address channel
- m_wvalid_o / m_wready_i / m_wdata_o[DATA_WIDTH] / m_wstrb_o[DATA_WIDTH/8]  AXI write data channel
- m_bvalid_i / m_bready_o / m_bresp_i[2]  AXI write response channel
- m_arvalid_o / m_arready_i / m_araddr_o[ADDR_WIDTH] / m_arprot_o[3]  AXI read address channel
- m_rvalid_i / m_rready_o / m_rdata_i[DATA_WIDTH] / m_rresp_i[2]  AXI read data channel

Behaviour:
- Clocking: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: FSM=IDLE; all outputs 0, including every valid/ready and data_rdata_o.
- Reset mid-transaction abandons the transaction with no response to the core. The system resets the interconnect together with the bridge.
- FSM states: IDLE, WR (AW/W pending), WRESP, RD_AR, RD_R.
- Grant: data_gnt_o = data_req_i && state==IDLE, combinational.
- On a grant, addr/be/wdata/we are latched. Next state is WR if we=1, otherwise RD_AR.
- Latched values drive the AXI channels unchanged. The bridge does not realign addresses.
- awprot and arprot are fixed at 3'b000.
- WR state:
  - m_awvalid_o is high until AW handshakes; m_wvalid_o is high until W handshakes.
  - Each channel is tracked by its own done flag and may complete in either order or the same cycle.
  - The valids are not dropped before their handshake, as AXI requires.
  - When both channels are done (including the cycle the last handshake occurs), go to WRESP and clear the flags.
- WRESP: m_bready_o=1. On bvalid, the next cycle pulses data_rvalid_o=1 with data_err_o=bresp[1] and data_rdata_o=0. State returns to IDLE on that same edge.
- RD_AR: m_arvalid_o=1 until arready, then go to RD_R.
- RD_R: m_rready_o=1. On rvalid, the next cycle pulses data_rvalid_o with data_rdata_o=rdata and data_err_o=rresp[1]. Return to IDLE.
- Back-to-back: a new request may be granted in the same cycle data_rvalid_o is high. Minimum throughput is one transaction per 3 cycles for reads and 3 cycles for writes with always-ready slaves.
- Latency with always-ready slaves: gnt at cycle 0; AXI valid at cycle 1; response handshake at cycle 2; data_rvalid_o at cycle 3.
- data_rdata_o holds its last value between responses. data_err_o is 0 whenever data_rvalid_o is 0.
- Inputs data_* are ignored outside the grant cycle.
- bvalid or rvalid arriving in an unexpected state is ignored; bready/rready stay 0 there.

Decomposition:
- Package tinyriscv_bus_pkg holds:
  - FSM state enum
  - AXI resp constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11
  - prot default constant
- No sub-module; a single FSM file.

Test Plan:
- Read, always-ready slave, addr=0x2000_0010, rdata=0xDEADBEEF, rresp=OKAY -> gnt at cycle 0, arvalid at cycle 1, rvalid_o at cycle 3 with rdata 0xDEADBEEF, err=0.
- Write addr=0x2000_0004, be=4'b0011, wdata=0x1234_5678; awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles; bready only after both; rvalid_o one cycle after B, err=0.
- Write with W handshake before AW and bresp=SLVERR -> data_err_o=1 on the rvalid pulse, data_rdata_o=0.
- Back-to-back read then write with req held high -> second gnt in the same cycle as the first rvalid_o; no cycle with two AXI valids from different transactions.
- Read with arready held low 10 cycles, then rresp=DECERR -> arvalid stable with a constant address for all 10 cycles; err=1.
- rst_n asserted while in WRESP -> all outputs 0 immediately (asynchronously); next request after release is granted from IDLE.
